// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the PWM ramp controller.
//   state_t      controller states (IDLE, RAMP)
//   DW_DEF       default duty/step width
//   PERIOD_W_DEF default period counter width (period = 2**PERIOD_W clk)
//   clamp_step   maps a requested step of 0 to 1
package pwm_pkg;

  localparam int DW_DEF       = 8;
  localparam int PERIOD_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  function automatic int unsigned clamp_step(input int unsigned step);
    return (step == 0) ? 32'd1 : step;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running PWM period timebase.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wrap         combinational; high while the counter sits at its maximum,
//                so the next posedge is the wrap edge
//   period_tick  registered; high in the first cycle of each period
//                (never in the first period after reset)
module pwm_period_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap,
  output logic period_tick
);

  logic [PERIOD_W-1:0] count;

  assign wrap = (count == {PERIOD_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      period_tick <= 1'b0;
    end else begin
      count       <= count + PERIOD_W'(1);
      period_tick <= wrap;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle sequencer for the PWM generator. Accepts
// {target, step} commands and ramps duty_out toward the target by one step
// per PWM period, updating only at period boundaries.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     high in IDLE; a transfer is cmd_valid && cmd_ready
//   cmd_duty      target duty
//   cmd_step      per-period increment (0 behaves as 1)
//   duty_out      registered duty to the generator
//   period_tick   first cycle of each period
//   busy          high while ramping
//   done          one-cycle pulse when the target is reached
//   abort         only when PWM_RAMP_ABORT_EN is defined; stops a ramp
//                 in place and returns to IDLE without done
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RAMP  | stepping duty_out at each wrap edge until it equals the target
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int          DW         = DW_DEF,
  parameter int          PERIOD_W   = PERIOD_W_DEF,
  parameter int unsigned RESET_DUTY = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_duty,
  input  logic [DW-1:0] cmd_step,
  output logic [DW-1:0] duty_out,
  output logic          period_tick,
  output logic          busy,
`ifdef PWM_RAMP_ABORT_EN
  input  logic          abort,
`endif
  output logic          done
);

  state_t        state, state_next;
  logic [DW-1:0] duty_next, target, step, step_eff, step_val, stepped;
  logic [DW:0]   diff;
  logic          done_next, wrap, accept, up, abort_req;

`ifdef PWM_RAMP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  pwm_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wrap        (wrap),
    .period_tick (period_tick)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RAMP);
  assign accept    = cmd_valid && cmd_ready;
  assign step_eff  = DW'(clamp_step(32'(cmd_step)));

  // The distance is taken one bit wider so it can never wrap. The stepped
  // value is only used when the distance exceeds the step, so it stays
  // strictly between duty_out and target and fits in DW bits.
  always_comb begin
    up       = (duty_out < target);
    diff     = up ? ({1'b0, target} - {1'b0, duty_out})
                  : ({1'b0, duty_out} - {1'b0, target});
    stepped  = up ? (duty_out + step) : (duty_out - step);
    step_val = (diff <= {1'b0, step}) ? target : stepped;
  end

  always_comb begin
    state_next = state;
    duty_next  = duty_out;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_duty == duty_out) done_next  = 1'b1;
          else                      state_next = RAMP;
        end
      end
      RAMP: begin
        if (abort_req) begin
          state_next = IDLE;
        end else if (wrap) begin
          duty_next = step_val;
          if (step_val == target) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_out <= DW'(RESET_DUTY);
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      duty_out <= duty_next;
      done     <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= DW'(RESET_DUTY);
      step   <= DW'(1);
    end else if (accept) begin
      target <= cmd_duty;
      step   <= step_eff;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl (default parameters: DW=8, 256-cycle period).
// The reference model predicts the duty at the k-th period tick after a
// command as the start value moved k*step toward the target, saturating at
// the target, with the ramp lasting ceil(|target-start|/step) periods.
module tb_pwm_ramp_ctrl;

  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_duty = '0;
  logic [7:0] cmd_step = '0;
  logic       cmd_ready, period_tick, busy, done;
  logic [7:0] duty_out;
`ifdef PWM_RAMP_ABORT_EN
  logic       abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cur = 0;
  logic [7:0] phase;

  always #5 clk = ~clk;

  // Bench-side view of where in the period we are; 0 means a tick cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) phase <= 8'd0;
    else        phase <= phase + 8'd1;

  pwm_ramp_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .cmd_step    (cmd_step),
    .duty_out    (duty_out),
    .period_tick (period_tick),
    .busy        (busy),
`ifdef PWM_RAMP_ABORT_EN
    .abort       (abort),
`endif
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next tick cycle; duty must hold and no tick may appear before it.
  task automatic next_tick(input int prev);
    int hold_bad = 0;
    for (int i = 0; i < PERIOD + 4; i++) begin
      @(negedge clk);
      if (phase == 8'd0) break;
      if (duty_out !== prev[7:0] || period_tick !== 1'b0 || done !== 1'b0) hold_bad++;
    end
    chk("hold", hold_bad, 0);
    chk("tick", period_tick, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input int d, input int s);
    cmd_duty  = d[7:0];
    cmd_step  = s[7:0];
    cmd_valid = 1'b1;
    chk("ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_ramp(input int tgt, input int stp, input bit collide);
    int s, delta, n, start, e, prev;
    start = cur;
    s     = (stp == 0) ? 1 : stp;
    delta = (tgt > start) ? tgt - start : start - tgt;
    n     = (delta + s - 1) / s;
    send_cmd(tgt, stp);
    if (n == 0) begin
      chk("eq_done", done, 1);
      chk("eq_busy", busy, 0);
      chk("eq_duty", duty_out, start);
      @(negedge clk);
      chk("eq_done_pulse", done, 0);
      return;
    end
    chk("busy_start", busy, 1);
    chk("done_start", done, 0);
    if (phase == 8'd0) begin
      chk("acc_wrap_tick", period_tick, 1);
      chk("acc_wrap_nostep", duty_out, start);
    end
    if (collide) begin
      cmd_valid = 1'b1;
      cmd_duty  = ~tgt[7:0];
      cmd_step  = 8'd1;
      chk("coll_ready", cmd_ready, 0);
    end
    prev = start;
    for (int k = 1; k <= n; k++) begin
      next_tick(prev);
      cmd_valid = 1'b0;
      if (tgt > start) e = (start + k * s > tgt) ? tgt : start + k * s;
      else             e = (start - k * s < tgt) ? tgt : start - k * s;
      chk("duty", duty_out, e);
      chk("done", done, (k == n));
      chk("busy", busy, (k < n));
      prev = e;
    end
    cur = tgt;
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int cnt, tgt, delta, stp;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", period_tick, 0);
    rst_n = 1'b1;
    chk("rel_ready", cmd_ready, 1);
    cnt = 0;
    for (int i = 1; i <= PERIOD + 40; i++) begin
      @(negedge clk);
      cnt = i;
      if (period_tick === 1'b1) break;
    end
    chk("first_tick", cnt, PERIOD);
    cur = 0;

    run_ramp(10, 4, 1'b0);      // 4, 8, 10
    run_ramp(50, 40, 1'b0);     // one period
    run_ramp(50, 7, 1'b0);      // equal target
    run_ramp(200, 50, 1'b1);    // cmd_valid held while busy
    run_ramp(0, 255, 1'b0);     // down, clamp at 0
    run_ramp(255, 255, 1'b0);   // up, clamp at max

    for (int i = 0; i < PERIOD + 4; i++) begin
      if (phase == 8'hFF) break;
      @(negedge clk);
    end
    run_ramp(245, 5, 1'b0);     // accepted on a wrap edge

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(200, 0)) @(negedge clk);
      tgt   = $urandom_range(255, 0);
      delta = (tgt > cur) ? tgt - cur : cur - tgt;
      stp   = $urandom_range(255, delta / 2 + 1);
      if (delta <= 2 && $urandom_range(1, 0) == 1) stp = 0;
      run_ramp(tgt, stp, 1'b0);
    end

    run_ramp(255, 255, 1'b0);
    run_ramp(0, 0, 1'b0);       // step 0 acts as 1: 255 periods

`ifdef PWM_RAMP_ABORT_EN
    send_cmd(100, 10);
    cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      next_tick(cnt);
      cnt = 10 * k;
      chk("ab_duty", duty_out, cnt);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_duty_frozen", duty_out, 30);
    chk("ab_done", done, 0);
    chk("ab_ready", cmd_ready, 1);
    next_tick(30);
    chk("ab_duty_after", duty_out, 30);
    chk("ab_done_after", done, 0);
    cur = 30;
    @(negedge clk);
`endif

    send_cmd(cur + 100, 1);
    next_tick(cur);
    chk("pre_rst_duty", duty_out, cur + 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", duty_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_tick", period_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rel_ready", cmd_ready, 1);
    @(negedge clk);
    chk("mid_rel_duty", duty_out, 0);
    chk("mid_rel_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
